// File: rtl/i2cs_arb_pkg.sv
// Shared types and constants for the I2C/APB register-RAM access arbiter.
package i2cs_arb_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I2C  = 2'd1,
    OWN_APB  = 2'd2
  } owner_e;

  // Counter limit from an integer parameter (callers keep values within 0..255).
  function automatic logic [CNT_W-1:0] cnt_limit(input int unsigned v);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/i2cs_sat_counter.sv
// Saturating 8-bit event counter with synchronous clear (clear wins) and an at-limit flag.
module i2cs_sat_counter
  import i2cs_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/i2cs_access_arbiter.sv
// Arbitrates the I2C and APB ports onto one single-port register RAM (read latency 1).
// Optional APB starvation guard enabled by defining I2CS_ARB_STARVE_GUARD_EN.
module i2cs_access_arbiter
  import i2cs_arb_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned LOCK_TMO = 64,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic          apb_pclk_i,
  input  logic          apb_presetn_i,
  input  logic          i2c_req_i,
  input  logic          i2c_we_i,
  input  logic          i2c_lock_i,
  input  logic [AW-1:0] i2c_addr_i,
  input  logic [DW-1:0] i2c_wdata_i,
  output logic          i2c_gnt_o,
  output logic          i2c_rvalid_o,
  output logic [DW-1:0] i2c_rdata_o,
  input  logic          apb_req_i,
  input  logic          apb_we_i,
  input  logic [AW-1:0] apb_addr_i,
  input  logic [DW-1:0] apb_wdata_i,
  output logic          apb_gnt_o,
  output logic          apb_rvalid_o,
  output logic [DW-1:0] apb_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          lock_tmo_o
);

  if ((LOCK_TMO < 1) || (LOCK_TMO > 255) || (MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_cfg
    $error("i2cs_access_arbiter: LOCK_TMO and MAX_WAIT must be within 1..255");
  end

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [DW-1:0] i2c_rdata_q, apb_rdata_q;
  logic          i2c_gnt_c, apb_gnt_c;
  logic          idle_inc_c, idle_clr_c, idle_at_tmo_c;
  logic          apb_starved_c;

  // Grant decision and next state; grants are suppressed while reset is asserted.
  always_comb begin
    state_d    = state_q;
    i2c_gnt_c  = 1'b0;
    apb_gnt_c  = 1'b0;
    lock_tmo_o = 1'b0;
    if (apb_presetn_i) begin
      unique case (state_q)
        ARB: begin
          if (apb_req_i && apb_starved_c) begin
            apb_gnt_c = 1'b1;
          end else if (i2c_req_i) begin
            i2c_gnt_c = 1'b1;
            if (i2c_lock_i) begin
              state_d = LOCK;
            end
          end else if (apb_req_i) begin
            apb_gnt_c = 1'b1;
          end
        end
        LOCK: begin
          i2c_gnt_c = i2c_req_i;
          if (!i2c_req_i && idle_at_tmo_c) begin
            lock_tmo_o = 1'b1;
            state_d    = ARB;
          end else if (!i2c_lock_i) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign i2c_gnt_o = i2c_gnt_c;
  assign apb_gnt_o = apb_gnt_c;
  assign mem_en_o  = i2c_gnt_c | apb_gnt_c;

  // RAM port mux; everything idles at zero when nobody is granted.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (i2c_gnt_c) begin
      mem_we_o    = i2c_we_i;
      mem_addr_o  = i2c_addr_i;
      mem_wdata_o = i2c_wdata_i;
    end else if (apb_gnt_c) begin
      mem_we_o    = apb_we_i;
      mem_addr_o  = apb_addr_i;
      mem_wdata_o = apb_wdata_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (i2c_gnt_c && !i2c_we_i) begin
      owner_d = OWN_I2C;
    end else if (apb_gnt_c && !apb_we_i) begin
      owner_d = OWN_APB;
    end
  end

  assign i2c_rvalid_o = (owner_q == OWN_I2C);
  assign apb_rvalid_o = (owner_q == OWN_APB);
  assign i2c_rdata_o  = i2c_rvalid_o ? mem_rdata_i : i2c_rdata_q;
  assign apb_rdata_o  = apb_rvalid_o ? mem_rdata_i : apb_rdata_q;

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      state_q     <= ARB;
      owner_q     <= OWN_NONE;
      i2c_rdata_q <= '0;
      apb_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      i2c_rdata_q <= i2c_rdata_o;
      apb_rdata_q <= apb_rdata_o;
    end
  end

  // Limit is LOCK_TMO-1 so the pulse lands on the LOCK_TMO-th idle cycle itself.
  assign idle_inc_c = (state_q == LOCK) && !i2c_req_i;
  assign idle_clr_c = i2c_gnt_c || (state_d != LOCK);

  i2cs_sat_counter u_idle_cnt (
    .clk_i      (apb_pclk_i),
    .rst_ni     (apb_presetn_i),
    .inc_i      (idle_inc_c),
    .clr_i      (idle_clr_c),
    .limit_i    (cnt_limit(LOCK_TMO - 1)),
    .at_limit_o (idle_at_tmo_c)
  );

`ifdef I2CS_ARB_STARVE_GUARD_EN
  logic starve_inc_c;

  assign starve_inc_c = (state_q == ARB) && apb_req_i && !apb_gnt_c;

  i2cs_sat_counter u_starve_cnt (
    .clk_i      (apb_pclk_i),
    .rst_ni     (apb_presetn_i),
    .inc_i      (starve_inc_c),
    .clr_i      (apb_gnt_c),
    .limit_i    (cnt_limit(MAX_WAIT)),
    .at_limit_o (apb_starved_c)
  );
`else
  assign apb_starved_c = 1'b0;
`endif

endmodule

// File: tb/tb_i2cs_access_arbiter.sv
// Directed self-checking bench for i2cs_access_arbiter with a behavioural single-port RAM.
module tb_i2cs_access_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i2c_req, i2c_we, i2c_lock;
  logic [AW-1:0] i2c_addr;
  logic [DW-1:0] i2c_wdata;
  logic          i2c_gnt, i2c_rvalid;
  logic [DW-1:0] i2c_rdata;
  logic          apb_req, apb_we;
  logic [AW-1:0] apb_addr;
  logic [DW-1:0] apb_wdata;
  logic          apb_gnt, apb_rvalid;
  logic [DW-1:0] apb_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          lock_tmo;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  i2cs_access_arbiter dut (
    .apb_pclk_i    (clk),
    .apb_presetn_i (rst_n),
    .i2c_req_i     (i2c_req),
    .i2c_we_i      (i2c_we),
    .i2c_lock_i    (i2c_lock),
    .i2c_addr_i    (i2c_addr),
    .i2c_wdata_i   (i2c_wdata),
    .i2c_gnt_o     (i2c_gnt),
    .i2c_rvalid_o  (i2c_rvalid),
    .i2c_rdata_o   (i2c_rdata),
    .apb_req_i     (apb_req),
    .apb_we_i      (apb_we),
    .apb_addr_i    (apb_addr),
    .apb_wdata_i   (apb_wdata),
    .apb_gnt_o     (apb_gnt),
    .apb_rvalid_o  (apb_rvalid),
    .apb_rdata_o   (apb_rdata),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .lock_tmo_o    (lock_tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv_i2c(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wdata);
    i2c_req = req; i2c_we = we; i2c_lock = lock; i2c_addr = addr; i2c_wdata = wdata;
  endtask

  task automatic drv_apb(input logic req, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata);
    apb_req = req; apb_we = we; apb_addr = addr; apb_wdata = wdata;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit seen;

    // Reset held with both requesters active: nothing may be granted.
    rst_n = 1'b0;
    drv_i2c(1'b1, 1'b1, 1'b0, 8'h10, 8'h11);
    drv_apb(1'b1, 1'b1, 8'h20, 8'h22);
    cyc(); cyc(); #1;
    check("rst_i2c_gnt", 32'(i2c_gnt), 32'd0);
    check("rst_apb_gnt", 32'(apb_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rvalid", 32'({i2c_rvalid, apb_rvalid}), 32'd0);
    check("rst_tmo", 32'(lock_tmo), 32'd0);

    // Release: I2C wins the first cycle, APB the next.
    cyc(); rst_n = 1'b1; #1;
    check("rel_i2c_gnt", 32'(i2c_gnt), 32'd1);
    check("rel_apb_gnt", 32'(apb_gnt), 32'd0);
    check("rel_mem", 32'({mem_we, mem_addr, mem_wdata}), 32'h11011);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    check("wr_apb_gnt", 32'(apb_gnt), 32'd1);
    check("wr_apb_mem", 32'({mem_we, mem_addr, mem_wdata}), 32'h12022);

    // Simultaneous reads: I2C first, APB next with I2C read data returning.
    cyc(); drv_i2c(1'b1, 1'b0, 1'b0, 8'h10, 8'h00); drv_apb(1'b1, 1'b0, 8'h20, 8'h00); #1;
    check("rd_i2c_gnt", 32'({i2c_gnt, apb_gnt}), 32'b10);
    check("rd_i2c_addr", 32'({mem_we, mem_addr}), 32'h010);
    check("rd_no_rvalid", 32'(i2c_rvalid), 32'd0);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    check("rd_apb_gnt", 32'({i2c_gnt, apb_gnt}), 32'b01);
    check("rd_apb_addr", 32'(mem_addr), 32'h20);
    check("rd_i2c_rvalid", 32'({i2c_rvalid, apb_rvalid}), 32'b10);
    check("rd_i2c_rdata", 32'(i2c_rdata), 32'h11);
    cyc(); drv_apb(1'b0, 1'b0, 8'h00, 8'h00); #1;
    check("rd_apb_rvalid", 32'({i2c_rvalid, apb_rvalid}), 32'b01);
    check("rd_apb_rdata", 32'(apb_rdata), 32'h22);
    check("rd_i2c_hold", 32'(i2c_rdata), 32'h11);
    check("rd_idle_en", 32'(mem_en), 32'd0);

    // Locked burst write blocks APB until the lock is dropped.
    cyc(); drv_i2c(1'b1, 1'b1, 1'b1, 8'h03, 8'h5A); drv_apb(1'b1, 1'b0, 8'h03, 8'h00); #1;
    check("lk_i2c_gnt", 32'({i2c_gnt, apb_gnt}), 32'b10);
    check("lk_wdata", 32'(mem_wdata), 32'h5A);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1 check("lk_apb_blocked", 32'({apb_gnt, mem_en}), 32'd0);
      cyc();
    end
    i2c_lock = 1'b0; #1;
    check("lk_release_cycle", 32'(apb_gnt), 32'd0);
    cyc(); #1;
    check("lk_apb_gnt", 32'(apb_gnt), 32'd1);
    check("lk_apb_addr", 32'(mem_addr), 32'h03);
    cyc(); drv_apb(1'b0, 1'b0, 8'h00, 8'h00); #1;
    check("lk_apb_rdata", 32'({apb_rvalid, apb_rdata}), 32'h15A);

    // Lock timeout after 64 idle cycles, APB granted right after.
    cyc(); drv_i2c(1'b1, 1'b1, 1'b1, 8'h04, 8'h77); drv_apb(1'b1, 1'b0, 8'h04, 8'h00); #1;
    check("to_i2c_gnt", 32'(i2c_gnt), 32'd1);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    for (int i = 1; i <= 64; i++) begin
      #1 check("to_pulse", 32'(lock_tmo), 32'(i == 64));
      check("to_apb_blocked", 32'(apb_gnt), 32'd0);
      cyc();
    end
    #1;
    check("to_apb_gnt", 32'(apb_gnt), 32'd1);
    check("to_pulse_gone", 32'(lock_tmo), 32'd0);
    check("to_apb_addr", 32'(mem_addr), 32'h04);
    cyc(); drv_apb(1'b0, 1'b0, 8'h00, 8'h00); drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    check("to_apb_rdata", 32'({apb_rvalid, apb_rdata}), 32'h177);

    // Continuous I2C traffic against a waiting APB requester.
    cyc(); drv_i2c(1'b1, 1'b1, 1'b0, 8'h05, 8'h00); drv_apb(1'b1, 1'b0, 8'h06, 8'h00);
`ifdef I2CS_ARB_STARVE_GUARD_EN
    for (int i = 1; i <= 17; i++) begin
      #1 check("sg_apb_gnt", 32'({i2c_gnt, apb_gnt}), (i == 17) ? 32'b01 : 32'b10);
      cyc();
    end
`else
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      #1 if (apb_gnt) k++;
      cyc();
    end
    check("sg_apb_starved", 32'(k), 32'd0);
`endif
    drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); drv_apb(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset in the cycle after a read grant drops the pending rvalid.
    cyc(); drv_i2c(1'b1, 1'b0, 1'b0, 8'h03, 8'h00); drv_apb(1'b1, 1'b0, 8'h03, 8'h00); #1;
    check("r6_i2c_gnt", 32'(i2c_gnt), 32'd1);
    cyc(); rst_n = 1'b0;
    drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); drv_apb(1'b0, 1'b0, 8'h00, 8'h00); #1;
    check("r6_no_rvalid", 32'({i2c_rvalid, apb_rvalid}), 32'd0);
    check("r6_no_en", 32'(mem_en), 32'd0);
    cyc(); cyc(); rst_n = 1'b1; #1;
    check("r6_rel_idle", 32'({mem_en, i2c_rvalid, apb_rvalid, lock_tmo}), 32'd0);

    // Lock timeout measured afresh after reset.
    cyc(); drv_i2c(1'b1, 1'b1, 1'b1, 8'h07, 8'h99); #1;
    check("r6_lock_gnt", 32'(i2c_gnt), 32'd1);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    k = 1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      #1;
      if (lock_tmo) seen = 1'b1;
      else begin
        k++;
        cyc();
      end
    end
    check("r6_tmo_cycle", 32'(k), 32'd64);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

`ifdef I2CS_ARB_STARVE_GUARD_EN
    cyc(); drv_i2c(1'b1, 1'b1, 1'b0, 8'h08, 8'h00); drv_apb(1'b1, 1'b1, 8'h09, 8'h00);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      k++;
      #1;
      if (apb_gnt) seen = 1'b1;
      else cyc();
    end
    check("r6_starve_cycle", 32'(k), 32'd17);
    cyc(); drv_i2c(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); drv_apb(1'b0, 1'b0, 8'h00, 8'h00);
`endif

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
